ave8_feeder: RTL

Sample-stream transmitter that drives the `ave8` moving-average filter from the producer side. It accepts 8-bit samples from a host over a valid/ready handshake and buffers them in a small FIFO. It issues them to `ave8` as single-cycle `in0`/`enable` strobes at a programmable pace. It then captures the filter result that belongs to each issued sample and returns it with a valid pulse. It sits between the host datapath and the `ave8` instance, so the filter always sees well-formed, paced input.

---
 rtl/ave8_feeder_if.sv | 27 ++
 rtl/ave8_feeder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ave8_feeder_if.sv
// Host-side and filter-side signal bundle for ave8_feeder.
// The slave modport is the feeder view; the master modport is the host/filter view.
interface ave8_feeder_if #(
  parameter int DEPTH = 8
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    host_data;
  logic          host_valid;
  logic          host_ready;
  logic [7:0]    smp_data;
  logic [7:0]    smp_en;
  logic [7:0]    avg_in;
  logic [7:0]    avg_out;
  logic          avg_valid;
  logic [LW-1:0] fifo_level;

  modport master (
    output host_data, host_valid, avg_in,
    input  host_ready, smp_data, smp_en, avg_out, avg_valid, fifo_level
  );

  modport slave (
    input  host_data, host_valid, avg_in,
    output host_ready, smp_data, smp_en, avg_out, avg_valid, fifo_level
  );
endinterface

// File: rtl/ave8_feeder.sv
// Paced sample feeder for the ave8 moving-average filter: host FIFO, ISSUE/WAIT pacing, result capture.
// Optional macro AVE8_FEEDER_WARMUP_EN suppresses avg_valid until the filter window holds 8 samples.
module ave8_feeder #(
  parameter int DEPTH = 8,
  parameter int GAP   = 0
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  ave8_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    gap_q, gap_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop;
  logic [7:0]    smp_data_q, smp_en_q;
  logic          vld_p0_q, vld_p1_q;
  logic          rep_p0_q, rep_p1_q, rep_d;
  logic [7:0]    avg_out_q;
  logic          avg_valid_q;
`ifdef AVE8_FEEDER_WARMUP_EN
  logic [3:0]    warm_q, warm_d;
`endif

  assign bus.host_ready = (level_q != LW'(DEPTH));
  assign push           = bus.host_valid && bus.host_ready;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        if (level_q != '0) begin
          pop = 1'b1;
          if (GAP > 0) begin
            gap_d   = 8'(GAP);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // A result is reported only once the sample that produced it completes the window.
  always_comb begin
`ifdef AVE8_FEEDER_WARMUP_EN
    warm_d = warm_q;
    if (pop && (warm_q != 4'd8)) warm_d = warm_q + 4'd1;
    rep_d = (warm_q >= 4'd7);
`else
    rep_d = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_ISSUE;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= bus.host_data;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      smp_data_q  <= 8'h00;
      smp_en_q    <= 8'h00;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      rep_p0_q    <= 1'b0;
      rep_p1_q    <= 1'b0;
      avg_out_q   <= 8'h00;
      avg_valid_q <= 1'b0;
`ifdef AVE8_FEEDER_WARMUP_EN
      warm_q      <= 4'd0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
`ifdef AVE8_FEEDER_WARMUP_EN
      warm_q  <= warm_d;
`endif
      // p0: issue strobe presented to ave8
      smp_en_q <= pop ? 8'hFF : 8'h00;
      if (pop) smp_data_q <= mem_q[rd_ptr_q];
      vld_p0_q <= pop;
      rep_p0_q <= rep_d;
      // p1: ave8 result for the p0 sample is on avg_in
      vld_p1_q <= vld_p0_q;
      rep_p1_q <= rep_p0_q;
      // p2: captured result
      if (vld_p1_q) avg_out_q <= bus.avg_in;
      avg_valid_q <= vld_p1_q && rep_p1_q;
    end
  end

  assign bus.smp_data   = smp_data_q;
  assign bus.smp_en     = smp_en_q;
  assign bus.avg_out    = avg_out_q;
  assign bus.avg_valid  = avg_valid_q;
  assign bus.fifo_level = level_q;
endmodule
